// File: rtl/cla_div_unit_if.sv
// cla_div_unit_if: start/busy/done handshake and operand/result bus of the radix-2 divider
interface cla_div_unit_if #(parameter int WIDTH = 32);
  logic             En;
  logic [WIDTH-1:0] Rs1;
  logic [WIDTH-1:0] Rs2;
  logic [1:0]       funct3_lo;
  logic [WIDTH-1:0] result;
  logic             busy;
  logic             done;
  modport master (output En, Rs1, Rs2, funct3_lo, input result, busy, done);
  modport slave  (input En, Rs1, Rs2, funct3_lo, output result, busy, done);
endinterface

// File: rtl/cla_div_unit.sv
// cla_div_unit: sequential radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
// DIV_EARLY_OUT_EN resolves divide-by-zero and signed overflow at the accept edge.
module cla_div_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input logic           CLK,
  input logic           rst_n,
  cla_div_unit_if.slave bus
);
  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;
  localparam logic [WIDTH-1:0] MIN = {1'b1, {(WIDTH-1){1'b0}}};
  state_t           r_state, w_next;
  logic [WIDTH-1:0] r_rem, r_quo, r_dvs, r_dvd, r_result;
  logic [CNT_W-1:0] r_cnt;
  logic             r_rsel, r_sq, r_sr, r_dz, r_ov, r_busy, r_done;
  logic [WIDTH-1:0] w_a_mag, w_b_mag, w_diff, w_q, w_r, w_fix_res, w_early_res;
  logic [WIDTH:0]   w_part;
  logic             w_signed, w_dz, w_ov, w_early, w_neg;
  assign w_signed = ~bus.funct3_lo[0];
  assign w_dz     = bus.Rs2 == '0;
  assign w_ov     = w_signed && bus.Rs1 == MIN && bus.Rs2 == '1;
`ifdef DIV_EARLY_OUT_EN
  assign w_early  = w_dz | w_ov;
`else
  assign w_early  = 1'b0;
`endif
  assign w_a_mag  = (w_signed && bus.Rs1[WIDTH-1]) ? -bus.Rs1 : bus.Rs1;
  assign w_b_mag  = (w_signed && bus.Rs2[WIDTH-1]) ? -bus.Rs2 : bus.Rs2;
  // rem < divisor keeps the shifted partial below 2*divisor, so bit WIDTH of the difference is the borrow
  assign w_part   = {r_rem, r_quo[WIDTH-1]};
  assign {w_neg, w_diff} = w_part - {1'b0, r_dvs};
  assign w_q         = r_dz ? '1 : r_ov ? MIN : (r_sq ? -r_quo : r_quo);
  assign w_r         = r_dz ? r_dvd : r_ov ? '0 : (r_sr ? -r_rem : r_rem);
  assign w_fix_res   = r_rsel ? w_r : w_q;
  assign w_early_res = bus.funct3_lo[1] ? (w_dz ? bus.Rs1 : '0) : (w_dz ? '1 : MIN);
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE: w_next = bus.En ? (w_early ? DONE : CALC) : IDLE;
      CALC: w_next = (r_cnt == CNT_W'(1)) ? FIX : CALC;
      FIX:  w_next = DONE;
      DONE: w_next = IDLE;
    endcase
  end
  always_ff @(posedge CLK) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end
  always_ff @(posedge CLK) begin
    if (!rst_n) begin
      r_rem    <= '0;
      r_quo    <= '0;
      r_dvs    <= '0;
      r_dvd    <= '0;
      r_result <= '0;
      r_cnt    <= '0;
      r_rsel   <= 1'b0;
      r_sq     <= 1'b0;
      r_sr     <= 1'b0;
      r_dz     <= 1'b0;
      r_ov     <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: if (bus.En) begin
          r_rsel <= bus.funct3_lo[1];
          r_sq   <= w_signed & (bus.Rs1[WIDTH-1] ^ bus.Rs2[WIDTH-1]);
          r_sr   <= w_signed & bus.Rs1[WIDTH-1];
          r_quo  <= w_a_mag;
          r_dvs  <= w_b_mag;
          r_rem  <= '0;
          r_dvd  <= bus.Rs1;
          r_dz   <= w_dz;
          r_ov   <= w_ov;
          r_cnt  <= CNT_W'(WIDTH);
          r_busy <= 1'b1;
          r_done <= w_early;
          if (w_early) r_result <= w_early_res;
        end
        CALC: begin
          r_rem <= w_neg ? w_part[WIDTH-1:0] : w_diff;
          r_quo <= {r_quo[WIDTH-2:0], ~w_neg};
          r_cnt <= r_cnt - CNT_W'(1);
        end
        FIX: begin
          r_result <= w_fix_res;
          r_busy   <= 1'b0;
          r_done   <= 1'b1;
        end
        DONE: begin
          r_busy <= 1'b0;
          r_done <= 1'b0;
        end
      endcase
    end
  end
  assign bus.result = r_result;
  assign bus.busy   = r_busy;
  assign bus.done   = r_done;
endmodule

// File: tb/tb_cla_div_unit.sv
// tb_cla_div_unit: randomized and directed checks of cla_div_unit against an arithmetic RV32M model
module tb_cla_div_unit;
  localparam int W = 32;
  localparam logic [31:0] MIN = 32'h8000_0000;
  logic clk = 1'b0;
  logic rst_n;
  int   n_chk = 0;
  int   n_fail = 0;
  cla_div_unit_if #(.WIDTH(W)) bus ();
  cla_div_unit #(.WIDTH(W), .CNT_W(6)) dut (.CLK(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  function automatic logic [31:0] model(input logic [31:0] a, input logic [31:0] b, input logic [1:0] f);
    logic [31:0] q, r;
    if (b == 0) begin
      q = '1;
      r = a;
    end else if (!f[0]) begin
      if (a == MIN && b == 32'hFFFF_FFFF) begin
        q = MIN;
        r = 0;
      end else begin
        q = $signed(a) / $signed(b);
        r = $signed(a) % $signed(b);
      end
    end else begin
      q = a / b;
      r = a % b;
    end
    return f[1] ? r : q;
  endfunction
  function automatic int exp_lat(input logic [31:0] a, input logic [31:0] b, input logic [1:0] f);
`ifdef DIV_EARLY_OUT_EN
    if (b == 0 || (!f[0] && a == MIN && b == 32'hFFFF_FFFF)) return 1;
`endif
    return W + 2;
  endfunction
  // one operation; lat counts the accept edge as cycle 1; poke drives En mid-op; b2b holds En through DONE
  task automatic op(input logic [31:0] a, input logic [31:0] b, input logic [1:0] f, input int poke, input bit b2b);
    logic [31:0] exp;
    int          lat, elat;
    bit          seen, busy_ok;
    exp  = model(a, b, f);
    elat = exp_lat(a, b, f);
    chk("idle_busy", {31'b0, bus.busy}, 0);
    chk("idle_done", {31'b0, bus.done}, 0);
    bus.En = 1'b1;
    bus.Rs1 = a;
    bus.Rs2 = b;
    bus.funct3_lo = f;
    @(posedge clk);
    @(negedge clk);
    bus.En = 1'b0;
    bus.Rs1 = $urandom;
    bus.Rs2 = $urandom;
    bus.funct3_lo = 2'($urandom_range(0, 3));
    lat = 1;
    seen = 0;
    busy_ok = 1;
    while (!seen && lat < 200) begin
      if (bus.done) seen = 1;
      else begin
        if (bus.busy !== 1'b1) busy_ok = 0;
        bus.En = (lat == poke);
        if (lat == poke) begin
          bus.Rs1 = $urandom;
          bus.Rs2 = $urandom;
        end
        @(negedge clk);
        lat++;
      end
    end
    chk("latency", lat, elat);
    chk("result", bus.result, exp);
    chk("busy_while_calc", {31'b0, busy_ok}, 1);
    chk("busy_at_done", {31'b0, bus.busy}, {31'b0, elat == 1});
    if (b2b) begin
      bus.En = 1'b1;
      bus.Rs1 = a;
      bus.Rs2 = b;
      bus.funct3_lo = f;
    end
    @(negedge clk);
    chk("done_pulse", {31'b0, bus.done}, 0);
    chk("result_hold", bus.result, exp);
  endtask
  initial begin
    logic [31:0] a, b;
    logic [1:0]  f;
    int          sel;
    rst_n = 1'b0;
    bus.En = 1'b0;
    bus.Rs1 = '0;
    bus.Rs2 = '0;
    bus.funct3_lo = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", {31'b0, bus.busy}, 0);
    chk("rst_done", {31'b0, bus.done}, 0);
    chk("rst_result", bus.result, 0);
    rst_n = 1'b1;
    @(negedge clk);
    op(100, 7, 2'b01, 0, 0);
    op(100, 7, 2'b11, 0, 1);
    op(32'hFFFF_FFF9, 2, 2'b00, 0, 0);
    op(32'hFFFF_FFF9, 2, 2'b10, 0, 0);
    op(32'h1234, 0, 2'b00, 0, 1);
    op(32'h1234, 0, 2'b10, 0, 0);
    op(32'hFFFF_FFF0, 0, 2'b00, 0, 0);
    op(32'h1234, 0, 2'b01, 0, 0);
    op(MIN, 32'hFFFF_FFFF, 2'b00, 0, 0);
    op(MIN, 32'hFFFF_FFFF, 2'b10, 0, 0);
    op(MIN, 32'hFFFF_FFFF, 2'b01, 0, 0);
    op(MIN, 1, 2'b00, 0, 0);
    op(1000, 10, 2'b01, 10, 0);
    op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'b11, 0, 0);
    bus.En = 1'b1;
    bus.Rs1 = 1000;
    bus.Rs2 = 10;
    bus.funct3_lo = 2'b01;
    @(posedge clk);
    @(negedge clk);
    bus.En = 1'b0;
    for (int c = 1; c < 20; c++) begin
      bus.En = (c == 10);
      bus.Rs1 = 5;
      bus.Rs2 = 5;
      @(negedge clk);
    end
    bus.En = 1'b0;
    chk("pre_rst_busy", {31'b0, bus.busy}, 1);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("abort_busy", {31'b0, bus.busy}, 0);
    chk("abort_done", {31'b0, bus.done}, 0);
    chk("abort_result", bus.result, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    op(9, 3, 2'b01, 0, 0);
    for (int i = 0; i < 50; i++) begin
      f = 2'($urandom_range(0, 3));
      a = $urandom >> $urandom_range(0, 31);
      if ($urandom_range(0, 1) == 1) a = -a;
      sel = $urandom_range(0, 7);
      b = (sel == 0) ? 32'h0 : (sel == 1) ? 32'($urandom_range(1, 15)) :
          (sel == 2) ? -32'($urandom_range(1, 15)) : ($urandom >> $urandom_range(0, 31));
      if (sel == 3) begin
        a = MIN;
        b = 32'hFFFF_FFFF;
      end
      op(a, b, f, ($urandom_range(0, 3) == 0) ? $urandom_range(2, 30) : 0, 1'($urandom_range(0, 1)));
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
